// File: rtl/neuron_mac.sv
// neuron_mac: sequential saturating multiply-accumulate neuron with valid/ready input and output handshakes
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int IN_W     = 5,
  parameter int ACC_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] bias,
  input  logic [IN_W-1:0]  x_in,
  input  logic [IN_W-1:0]  w_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0] cnt;
  logic [2*IN_W-1:0] p;
  logic [ACC_W:0] s;
  logic [ACC_W-1:0] sat;
  // low 2*IN_W bits of the product of sign-extended operands are the exact signed product
  always_comb begin
    p = {{IN_W{x_in[IN_W-1]}}, x_in} * {{IN_W{w_in[IN_W-1]}}, w_in};
    s = {acc[ACC_W-1], acc} + {{(ACC_W+1-2*IN_W){p[2*IN_W-1]}}, p};
    sat = (s[ACC_W] ^ s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
  end
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= bias;
          cnt   <= '0;
          state <= ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc <= sat;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed checks of neuron_mac against a per-term saturating sum model
module tb_neuron_mac;
  localparam int N = 4;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [11:0] bias = '0;
  logic [4:0] x_in = '0, w_in = '0;
  logic in_ready, out_valid, busy;
  logic [11:0] out_data;
  int cmp = 0, mis = 0;
  int xs[N], ws[N];
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  neuron_mac #(.N_INPUTS(N), .IN_W(5), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .x_in(x_in), .w_in(w_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model(int b);
    int a = b;
    for (int i = 0; i < N; i++) begin
      a = a + xs[i] * ws[i];
      if (a > 2047) a = 2047;
      if (a < -2048) a = -2048;
    end
    return a;
  endfunction

  task automatic test_reset;
    cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 12'h000) begin
      mis++;
      $display("FAIL reset_hold: rdy/vld/busy=%b data=%h, want 000 data=000", {in_ready, out_valid, busy}, out_data);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      mis++;
      $display("FAIL reset_release: rdy/vld/busy=%b, want 000", {in_ready, out_valid, busy});
    end
  endtask

  // mode: 0 continuous in_valid, 1 fixed gap pattern, 2 random gaps
  task automatic run_eval(input string nm, input int b, input int mode, input int bp, input bit noise, input bit chk_lat);
    int acc_cnt, cyc, lat, v;
    logic [11:0] e;
    e = 12'(model(b));
    bias = b[11:0]; start = 1;
    @(posedge clk); #1 start = 0;
    lat = 1;
    cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      mis++;
      $display("FAIL %s start: busy=%b in_ready=%b, want 1 1", nm, busy, in_ready);
    end
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < N && cyc < 200) begin
      v = (mode == 0) ? 1 : (mode == 1) ? pat[cyc % 7] : int'($urandom_range(0, 1));
      in_valid = v[0];
      x_in = v[0] ? xs[acc_cnt][4:0] : 5'($urandom);
      w_in = v[0] ? ws[acc_cnt][4:0] : 5'($urandom);
      if (noise && cyc == 1) start = 1;
      @(posedge clk); #1 start = 0;
      if (v[0]) acc_cnt++;
      cyc++; lat++;
      if (acc_cnt < N) begin
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          mis++;
          $display("FAIL %s accum: in_ready=%b out_valid=%b, want 1 0", nm, in_ready, out_valid);
        end
      end
    end
    in_valid = 0;
    if (cyc >= 200) begin
      mis++;
      $display("FAIL %s timeout: accepted=%0d, want %0d", nm, acc_cnt, N);
    end
    cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e) begin
      mis++;
      $display("FAIL %s result: vld=%b rdy=%b data=%h, want 1 0 %h", nm, out_valid, in_ready, out_data, e);
    end
    if (chk_lat) begin
      cmp++;
      if (lat !== N + 1) begin
        mis++;
        $display("FAIL %s latency: got %0d, want %0d", nm, lat, N + 1);
      end
    end
    for (int k = 0; k < bp; k++) begin
      if (noise) begin start = 1; in_valid = 1; x_in = 5'($urandom); w_in = 5'($urandom); end
      @(posedge clk); #1;
      cmp++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        mis++;
        $display("FAIL %s hold%0d: vld=%b rdy=%b data=%h, want 1 0 %h", nm, k, out_valid, in_ready, out_data, e);
      end
    end
    out_ready = 1; start = noise; in_valid = noise;
    @(posedge clk); #1 out_ready = 0; start = 0;
    cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      mis++;
      $display("FAIL %s drain: vld=%b busy=%b rdy=%b, want 0 0 0", nm, out_valid, busy, in_ready);
    end
    if (noise) begin
      @(posedge clk); #1;
      cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
        mis++;
        $display("FAIL %s idle_pairs: busy=%b rdy=%b, want 0 0", nm, busy, in_ready);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_basic;
    xs = '{3, -4, 7, 0}; ws = '{2, 5, 1, 15};
    run_eval("basic", 0, 0, 0, 0, 1);
  endtask

  task automatic test_saturation;
    xs = '{-16, 0, 0, 0}; ws = '{-16, 0, 0, 0};
    run_eval("sat_pos", 2000, 0, 0, 0, 0);
    xs = '{-16, -16, -16, -16}; ws = '{15, 15, 15, 15};
    run_eval("sat_neg", -2000, 0, 0, 0, 0);
    xs = '{15, -16, 0, 0}; ws = '{15, 15, 0, 0};
    run_eval("sat_recover", 2047, 0, 0, 0, 0);
  endtask

  task automatic test_gaps_backpressure;
    xs = '{5, -3, 2, 11}; ws = '{-7, 9, 4, -2};
    run_eval("gaps_bp", 100, 1, 5, 0, 0);
  endtask

  task automatic test_ignored_controls;
    xs = '{3, -4, 7, 0}; ws = '{2, 5, 1, 15};
    run_eval("ignored", 0, 2, 3, 1, 0);
  endtask

  task automatic test_reset_mid;
    xs = '{9, 9, 9, 9}; ws = '{9, 9, 9, 9};
    bias = 12'd50; start = 1;
    @(posedge clk); #1 start = 0;
    in_valid = 1; x_in = 5'd9; w_in = 5'd9;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1;
    cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 12'h000) begin
      mis++;
      $display("FAIL reset_mid: rdy/vld/busy=%b data=%h, want 000 data=000", {in_ready, out_valid, busy}, out_data);
    end
    in_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    cmp++;
    if (busy !== 1'b0) begin
      mis++;
      $display("FAIL reset_mid_idle: busy=%b, want 0", busy);
    end
    xs = '{1, 1, 1, 1}; ws = '{1, 1, 1, 1};
    run_eval("after_reset", 5, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = int'($urandom_range(0, 31)) - 16;
        ws[i] = int'($urandom_range(0, 31)) - 16;
      end
      run_eval($sformatf("rand%0d", t), int'($urandom_range(0, 4095)) - 2048, 2, int'($urandom_range(0, 3)), t[0], 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_saturation;
    test_gaps_backpressure;
    test_ignored_controls;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate neuron that produces the 12-bit signed pre-activation sum consumed by the downstream ReLU/truncation activation stage.
- Takes N_INPUTS pairs of 5-bit signed activation and weight operands, one pair per accepted beat, starting from a 12-bit signed bias.
- Saturates the running sum to 12 bits.
- Presents the result on a valid/ready output handshake.

Parameters:
- N_INPUTS, 4, number of x*w terms per neuron evaluation (2..64).
- IN_W, 5, width of x_in and w_in (two's complement).
- ACC_W, 12, accumulator/output width (two's complement); must be >= 2*IN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a new evaluation; sampled only in IDLE.
- bias  input  ACC_W  signed initial accumulator value, captured on accepted start.
- x_in  input  IN_W  signed activation operand.
- w_in  input  IN_W  signed weight operand.
- in_valid  input  1  x_in/w_in pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- out_data  output  ACC_W  signed saturated sum.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_data=0, busy=0. Reset mid-evaluation discards the partial sum. No output is produced for the aborted evaluation.
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst.
- State machine: IDLE, ACCUM, DONE.

IDLE:
- in_ready=0, out_valid=0.
- On start=1: acc<=bias, cnt<=0, next state ACCUM.
- Pairs presented in IDLE are not accepted.

ACCUM:
- in_ready=1 combinationally (registered state only, not a function of in_valid).
- Accept = in_valid & in_ready.
- On accept: p = x_in*w_in as a 2*IN_W-bit signed product, sign-extended to ACC_W+1 bits.
  - s = acc + p at ACC_W+1 bits.
  - acc <= clamp(s, -2^(ACC_W-1), 2^(ACC_W-1)-1), i.e. -2048..2047 by default.
  - cnt <= cnt+1.
- On accept with cnt==N_INPUTS-1: next state DONE. The last term is included.
- No accept: acc and cnt hold. Gaps in in_valid are legal.
- start is ignored in ACCUM.

DONE:
- out_valid=1, out_data=acc, in_ready=0.
- out_data is stable while out_valid=1 & out_ready=0.
- On out_ready=1: next state IDLE, out_valid falls the following cycle.
- start in the same cycle as out_ready is ignored. A new evaluation needs start in IDLE, so minimum spacing is one idle cycle.

Arithmetic and timing:
- Saturation is applied per term, not only at the end. Once clamped, later terms may move acc back inside range.
- Latency: the result is visible 1 cycle after the last accepted pair. With continuous in_valid, start-to-out_valid is N_INPUTS+1 cycles.
- out_data holds its last value after leaving DONE. It is only meaningful while out_valid=1.

Test Plan:
- Basic sum: bias=0, pairs (3,2),(−4,5),(7,1),(0,15), in_valid continuous. Result: out_valid 5 cycles after start, out_data=6−20+7+0=−7 (0xFF9).
- Positive saturation: bias=2000, pairs (−16,−16),(0,0),(0,0),(0,0). Expected: 2000+256 clamps to 2047 (0x7FF). Then bias=−2000 with four (−16,15) terms gives −2960, clamped per term, out_data=−2048 (0x800).
- Per-term clamp recovery: bias=2047, pairs (15,15),(−16,15),(0,0),(0,0). Expected: 2047 saturates then −240, out_data=1807.
- Handshake gaps and backpressure: in_valid toggled 1,0,0,1,1,0,1. Expected: exactly 4 accepts and in_ready=0 after the 4th. Hold out_ready=0 for 5 cycles: out_valid and out_data stable. out_ready=1: out_valid=0 next cycle, busy=0.
- Ignored controls: start pulsed during ACCUM and DONE, and pairs with in_valid=1 in IDLE. Expected: no restart, no extra accumulation, result unchanged from the scenario without them.
- Reset mid-operation: rst=0 asynchronously after 2 accepts. Expected: out_valid=0, busy=0, in_ready=0 immediately. Next evaluation with bias=5 and (1,1)×4 gives out_data=9.
